// File: rtl/ldl_crc32_chk_arb.sv
// ldl_crc32_chk_arb: frame-granular round-robin arbiter that streams one
// requester's frame at a time through a shared LDL_crc32_d8 byte engine and
// reports a tagged pass/fail result per frame.
// Optional feature macro: LDL_CRC_ARB_TIMEOUT_EN (idle timeout inside a frame).

// Byte-wide CRC-32 step, poly 04C11DB7, MSB-first register, d[7] shifted in first.
module LDL_crc32_d8 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] c;
  logic        fb;

  // Eight serial LFSR steps unrolled into one combinational update.
  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    crc_out = c;
  end
endmodule

module ldl_crc32_chk_arb #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDW     = $clog2(N),
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_eof,
  output logic [N-1:0]     req_ready,
  output logic             res_valid,
  output logic             res_err,
  output logic             res_abort,
  output logic [IDW-1:0]   res_id,
  output logic [15:0]      res_len,
  output logic             busy
);
  localparam int unsigned LW      = 16;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE  = 32'hC704_DD7B;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  g;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_inc;
  logic [IDW-1:0]  grant_nxt;
  logic            grant_hit;
  logic [31:0]     crc;
  logic [31:0]     crc_out;
  logic [LW-1:0]   len;
  logic [LW-1:0]   len_inc;
  logic [7:0]      g_byte;
  logic [7:0]      g_byte_rev;
  logic            accept;
  logic            eof_acc;
  logic            timeout_hit;

  // Granted channel's byte, bit-reversed so the engine sees LSB first.
  always_comb begin
    g_byte = req_data[{g, 3'b000} +: 8];
    for (int i = 0; i < 8; i++) g_byte_rev[i] = g_byte[7-i];
  end

  LDL_crc32_d8 u_crc (
    .crc_in  (crc),
    .d       (g_byte_rev),
    .crc_out (crc_out)
  );

  assign accept  = (state == S_RUN) && req_valid[g];
  assign eof_acc = accept && req_eof[g];
  assign len_inc = (len == {LW{1'b1}}) ? len : len + LW'(1);
  assign ptr_inc = (g == IDW'(N-1)) ? '0 : g + IDW'(1);

  // Cyclic search for the first requesting channel at or after ptr.
  always_comb begin
    int unsigned idx;
    grant_hit = 1'b0;
    grant_nxt = '0;
    idx       = 0;
    for (int k = 0; k < int'(N); k++) begin
      idx = (32'(ptr) + 32'(k)) % N;
      if (!grant_hit && req_valid[IDW'(idx)]) begin
        grant_hit = 1'b1;
        grant_nxt = IDW'(idx);
      end
    end
  end

`ifdef LDL_CRC_ARB_TIMEOUT_EN
  logic [15:0] idle_cnt;

  // Idle-cycle counter for the granted channel; cleared by any accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state != S_RUN || accept || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  // Limit reached when this idle cycle would bring the count to TIMEOUT; eof wins.
  assign timeout_hit = (state == S_RUN) && !accept &&
                       ((17'(idle_cnt) + 17'd1) >= 17'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
  assign res_abort   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: grant locks for a whole frame.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_hit) state_nxt = S_RUN;
      S_RUN:   if (eof_acc || timeout_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state and grant.
  always_comb begin
    req_ready = '0;
    busy      = (state == S_RUN);
    if (state == S_RUN) req_ready = N'(1) << g;
  end

  // Frame datapath, round-robin pointer and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g         <= '0;
      ptr       <= '0;
      crc       <= CRC_INIT;
      len       <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_id    <= '0;
      res_len   <= '0;
`ifdef LDL_CRC_ARB_TIMEOUT_EN
      res_abort <= 1'b0;
`endif
    end else begin
      res_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (grant_hit) begin
          g   <= grant_nxt;
          crc <= CRC_INIT;
          len <= '0;
        end
      end else if (accept) begin
        crc <= crc_out;
        len <= len_inc;
        if (req_eof[g]) begin
          res_valid <= 1'b1;
          res_err   <= (crc_out != RESIDUE);
          res_id    <= g;
          res_len   <= len_inc;
          ptr       <= ptr_inc;
`ifdef LDL_CRC_ARB_TIMEOUT_EN
          res_abort <= 1'b0;
`endif
        end
      end else if (timeout_hit) begin
        res_valid <= 1'b1;
        res_err   <= 1'b1;
        res_id    <= g;
        res_len   <= len;
        ptr       <= ptr_inc;
`ifdef LDL_CRC_ARB_TIMEOUT_EN
        res_abort <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_ldl_crc32_chk_arb.sv
// Scoreboard bench for ldl_crc32_chk_arb: drivers push expected results,
// a monitor pops and compares whenever res_valid is seen.
module tb_ldl_crc32_chk_arb;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int id;
    int len;
    int err;
    int abort;
    int lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_eof;
  logic [N-1:0]     req_ready;
  logic             res_valid;
  logic             res_err;
  logic             res_abort;
  logic [IDW-1:0]   res_id;
  logic [15:0]      res_len;
  logic             busy;

  logic             ch_valid[N];
  logic [7:0]       ch_data[N];
  logic             ch_eof[N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int last_eof_cyc = 0;
  exp_t sb[$];

  bq_t good  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
  bq_t bad   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h36, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
  bq_t one   = '{8'h00};
  bq_t part5 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
  bq_t part3 = '{8'h31, 8'h32, 8'h33};

  ldl_crc32_chk_arb #(.N(N), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_eof   (req_eof),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_err   (res_err),
    .res_abort (res_abort),
    .res_id    (res_id),
    .res_len   (res_len),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = ch_valid[i];
      req_data[8*i +: 8]   = ch_data[i];
      req_eof[i]           = ch_eof[i];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present bytes on one channel; called and returns at a falling edge.
  // mode 1: first ready exactly one cycle after valid; mode 2: two cycles after previous eof.
  task automatic send(input int ch, input bq_t bytes, input bit with_eof, input int mode);
    int waited;
    for (int i = 0; i < bytes.size(); i++) begin
      ch_valid[ch] = 1'b1;
      ch_data[ch]  = bytes[i];
      ch_eof[ch]   = with_eof && (i == bytes.size() - 1);
      waited = 0;
      while (!req_ready[ch] && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (!req_ready[ch]) begin
        chk("ready_wait_expired", 0, 1);
        break;
      end
      if (i == 0 && mode == 1) chk("grant_latency", waited, 1);
      if (i == 0 && mode == 2) chk("interframe_gap", cyc - last_eof_cyc, 2);
      last_acc_cyc = cyc;
      if (ch_eof[ch]) last_eof_cyc = cyc;
      @(negedge clk);
    end
    ch_valid[ch] = 1'b0;
    ch_eof[ch]   = 1'b0;
  endtask

  task automatic push(input int id, input int len, input int err, input int abort, input int lat);
    exp_t e;
    e.id = id; e.len = len; e.err = err; e.abort = abort; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("results_outstanding", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares every result strobe against the scoreboard head.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev = 1'b0;
      end else begin
        chk("ready_onehot0", int'($onehot0(req_ready)), 1);
        if (res_valid) begin
          if (prev) chk("res_valid_single_cycle", 1, 0);
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("res_id", int'(res_id), e.id);
            chk("res_len", int'(res_len), e.len);
            chk("res_err", int'(res_err), e.err);
            chk("res_abort", int'(res_abort), e.abort);
            chk("res_latency", cyc - last_acc_cyc, e.lat);
          end
        end
        prev = res_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      ch_valid[i] = 1'b0;
      ch_data[i]  = 8'h00;
      ch_eof[i]   = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_err", int'(res_err), 0);
    chk("rst_res_abort", int'(res_abort), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_len", int'(res_len), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Round robin with every channel requesting: 0,1,2,3,0.
    push(0, 13, 0, 0, 1);
    push(1, 13, 0, 0, 1);
    push(2, 13, 0, 0, 1);
    push(3, 13, 0, 0, 1);
    push(0, 13, 0, 0, 1);
    fork
      begin
        send(0, good, 1'b1, 1);
        send(0, good, 1'b1, 2);
      end
      send(1, good, 1'b1, 2);
      send(2, good, 1'b1, 2);
      send(3, good, 1'b1, 2);
    join
    drain();

    // Good "123456789" frame on channel 1.
    push(1, 13, 0, 0, 1);
    send(1, good, 1'b1, 1);
    drain();

    // Corrupted byte 5.
    push(1, 13, 1, 0, 1);
    send(1, bad, 1'b1, 1);
    drain();

    // One-byte frame on channel 2 leaves ptr at 3.
    push(2, 1, 1, 0, 1);
    send(2, one, 1'b1, 1);
    drain();

    // Reset mid-frame on channel 3; ptr must return to 0.
    send(3, part5, 1'b0, 1);
    chk("busy_mid_frame", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req_ready", int'(req_ready), 0);
    chk("rst_mid_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(1, 13, 0, 0, 1);
    push(3, 13, 0, 0, 1);
    fork
      send(1, good, 1'b1, 1);
      send(3, good, 1'b1, 0);
    join
    drain();

`ifdef LDL_CRC_ARB_TIMEOUT_EN
    // Channel 0 stalls after 3 bytes; channel 1 follows.
    push(0, 3, 1, 1, TO + 1);
    push(1, 13, 0, 0, 1);
    send(0, part3, 1'b0, 1);
    send(1, good, 1'b1, 0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ldl_crc32_chk_arb.md
# ldl_crc32_chk_arb

Frame-granular round-robin arbiter and sequencer that shares one `LDL_crc32_d8` byte engine between N byte-stream requesters. Each requester presents a frame ending in its 4-byte FCS. The block grants one requester per frame, streams that frame's bytes through the engine, and reports a per-frame pass/fail result tagged with the channel ID and byte count. It sits between the per-port receive FIFOs and the frame-status logic.

## Interface
- `N`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(N)`: channel ID width.
- `TIMEOUT`, 255: idle-cycle limit inside a granted frame. Used only with the timeout feature; range 1..65535.

- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  N: per-channel byte valid.
- `req_data`  in  8*N: per-channel byte; channel i uses `[8i+7:8i]`.
- `req_eof`  in  N: per-channel last-byte flag, qualified by valid.
- `req_ready`  out  N: per-channel byte accept, one-hot or zero.
- `res_valid`  out  1: one-cycle result strobe.
- `res_err`  out  1: FCS check failed, or the frame was aborted.
- `res_abort`  out  1: frame terminated by timeout.
- `res_id`  out  IDW: channel of the reported frame.
- `res_len`  out  16: bytes accepted in the frame, saturating at 16'hFFFF.
- `busy`  out  1: state is RUN.

## Operation
- The engine is one instance of `LDL_crc32_d8`.
  - Data input is the bit-reversed byte, `{d[0],…,d[7]}`.
  - The CRC register is 32 bits.
  - On a frame start, the CRC register is loaded with 32'hFFFFFFFF.
- A byte is accepted when `req_valid[g] && req_ready[g]`. On acceptance, `crc <= crc_out` and `len <= len+1`, saturating.
- Pass criterion: on the eof byte, `crc_out == 32'hC704DD7B`. That is the residue of the data plus the FCS transmitted LSB-first.
- State machine:
  - IDLE: `req_ready=0`. If any `req_valid` is high, grant = the first asserted channel at or after `ptr`, searching cyclically. Then load crc = all-ones and len = 0, and go to RUN. Otherwise stay in IDLE.
  - RUN: `req_ready[g]=1`. When an eof byte is accepted: capture the result, set `ptr <= (g+1) mod N`, and go to IDLE.
- The grant is locked for a whole frame. Other channels' valid/eof are ignored in RUN.
- Result registers:
  - `res_id`, `res_len`, `res_err` and `res_abort` update only with `res_valid`.
  - They hold their values between strobes.
- A frame of fewer than 4 bytes is processed normally; its residue will not match, so `res_err=1`.
- `req_eof` without `req_valid` is ignored.
- Reset values:
  - State IDLE, `ptr=0`, crc=all-ones, len=0.
  - `req_ready=0`, `res_valid=0`, `res_err=0`, `res_abort=0`, `res_id=0`, `res_len=0`, `busy=0`.
- Reset mid-frame discards the frame and emits no result. The requester must restart its frame.

## Timing
- Grant latency:
  - Valid seen in IDLE at cycle t gives `req_ready[g]=1` from t+1.
  - The first byte can be accepted at t+1.
- Throughput is one byte per cycle while granted.
- Result latency: eof accepted at cycle t gives `res_valid=1` at t+1 only, and state is IDLE at t+1.
- Minimum inter-frame gap is one IDLE cycle. The next grant is evaluated at t+1 and ready asserts at t+2.
- All outputs are registered, except `req_ready`, which is decoded from registered state and grant.

## Configuration
- `LDL_CRC_ARB_TIMEOUT_EN` defined:
  - In RUN, a 16-bit idle counter resets on every accepted byte and increments on cycles where `req_valid[g]=0`.
  - When the counter reaches `TIMEOUT`: `res_valid`, `res_err=1` and `res_abort=1` are asserted the next cycle, `ptr` advances, and the state goes to IDLE.
  - An eof byte accepted in the same cycle the limit is reached wins: it yields a normal result.
- `LDL_CRC_ARB_TIMEOUT_EN` undefined:
  - No counter is built, and `res_abort` is tied to 0.
  - A stalled granted channel holds the engine indefinitely.

## Test plan
- Channel 1 sends ASCII "123456789" then 26 39 F4 CB, with eof on CB, one byte per cycle → one `res_valid`; `res_err=0`, `res_id=1`, `res_len=13`.
- Same frame with byte 5 changed from 0x35 to 0x36 → `res_err=1`, `res_len=13`.
- All 4 channels request continuously with good frames → grants follow the order 0,1,2,3,0. Each eof is followed by exactly one idle cycle before the next `req_ready`.
- A 1-byte frame (0x00 with eof) on channel 2 → `res_err=1`, `res_len=1`, result one cycle after accept.
- `rst` pulsed after 5 bytes of a frame on channel 3 → `req_ready=0` and `busy=0` immediately, no `res_valid`, `ptr=0`. A restarted good frame then passes.
- With `LDL_CRC_ARB_TIMEOUT_EN` and `TIMEOUT=8`, channel 0 stalls after 3 bytes → `res_valid` with `res_abort=1`, `res_err=1`, `res_len=3`, 9 cycles after the last accepted byte. Channel 1 is granted next.
